// File: rtl/xentry_pkg.sv
// Shared types for the L2 responder: memory operation codes and responder FSM states.
package xentry_pkg;

  typedef enum logic [1:0] {
    LOAD       = 2'd0,
    STORE      = 2'd1,
    MO_UNKNOWN = 2'd2
  } memory_operation_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RESPOND = 2'd2,
    ST_GAP     = 2'd3
  } l2_responder_state_e;

  function automatic logic is_mem_op(memory_operation_e op);
    return (op == LOAD) || (op == STORE);
  endfunction

endpackage

// File: rtl/l2_responder_if.sv
// dcache <-> L2 request/response bundle; master is the dcache side, slave the responder.
interface l2_responder_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int XLEN       = 32
);
  logic                          l2_req_valid;
  xentry_pkg::memory_operation_e l2_req_type;
  logic [ADDR_WIDTH-1:0]         l2_req_address;
  logic [XLEN-1:0]               l2_req_store_word;
  logic                          l2_req_fulfilled;
  logic [XLEN-1:0]               l2_req_loaded_word;

  modport master (
    output l2_req_valid, l2_req_type, l2_req_address, l2_req_store_word,
    input  l2_req_fulfilled, l2_req_loaded_word
  );

  modport slave (
    input  l2_req_valid, l2_req_type, l2_req_address, l2_req_store_word,
    output l2_req_fulfilled, l2_req_loaded_word
  );
endinterface

// File: rtl/l2_memory_array.sv
// Single-port backing store with synchronous read/write; read register holds between reads.
module l2_memory_array #(
  parameter int ADDR_WIDTH = 10,
  parameter int XLEN       = 32
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [XLEN-1:0]       wdata,
  output logic [XLEN-1:0]       rdata
);
  logic [XLEN-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk)
    if (en && we) mem[addr] <= wdata;

  // Only the read register is reset; array contents survive reset.
  always_ff @(posedge clk)
    if (!reset_n)        rdata <= '0;
    else if (en && !we)  rdata <= mem[addr];
endmodule

// File: rtl/l2_responder.sv
// Fixed-latency L2 responder for dcache beats. Define XENTRY_L2_STATS_EN to add
// saturating load_count/store_count outputs.
module l2_responder
  import xentry_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int XLEN       = 32,
  parameter int LATENCY    = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  l2_responder_if.slave bus
`ifdef XENTRY_L2_STATS_EN
  ,
  output logic [31:0]  load_count,
  output logic [31:0]  store_count
`endif
);
  l2_responder_state_e   state, state_nx;
  logic [3:0]            wait_cnt, wait_nx;
  memory_operation_e     lat_type;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [XLEN-1:0]       lat_word;
  logic                  accept, fulfilled, mem_en, mem_we;

  always_ff @(posedge clk)
    if (!reset_n) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_nx;
    end

  always_ff @(posedge clk)
    if (accept) begin
      lat_type <= bus.l2_req_type;
      lat_addr <= bus.l2_req_address;
      lat_word <= bus.l2_req_store_word;
    end

  always_comb begin
    state_nx  = state;
    wait_nx   = wait_cnt;
    accept    = 1'b0;
    fulfilled = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    case (state)
      ST_IDLE:
        if (bus.l2_req_valid && is_mem_op(bus.l2_req_type)) begin
          accept   = 1'b1;
          wait_nx  = 4'(LATENCY - 1);
          state_nx = ST_BUSY;
        end
      ST_BUSY:
        if (wait_cnt == 4'd0) begin
          // Read launches here so data sits in the read register during ST_RESPOND.
          mem_en   = (lat_type == LOAD);
          state_nx = ST_RESPOND;
        end else begin
          wait_nx = wait_cnt - 4'd1;
        end
      ST_RESPOND: begin
        fulfilled = 1'b1;
        mem_en    = (lat_type == STORE);
        mem_we    = (lat_type == STORE);
        state_nx  = ST_GAP;
      end
      ST_GAP:   state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Reset gating keeps an aborted beat from writing or pulsing fulfilled.
  assign bus.l2_req_fulfilled = fulfilled & reset_n;

  l2_memory_array #(.ADDR_WIDTH(ADDR_WIDTH), .XLEN(XLEN)) u_mem (
    .clk    (clk),
    .reset_n(reset_n),
    .en     (mem_en & reset_n),
    .we     (mem_we),
    .addr   (lat_addr),
    .wdata  (lat_word),
    .rdata  (bus.l2_req_loaded_word)
  );

`ifdef XENTRY_L2_STATS_EN
  always_ff @(posedge clk)
    if (!reset_n) begin
      load_count  <= '0;
      store_count <= '0;
    end else if (bus.l2_req_fulfilled) begin
      if (lat_type == LOAD  && load_count  != '1) load_count  <= load_count  + 32'd1;
      if (lat_type == STORE && store_count != '1) store_count <= store_count + 32'd1;
    end
`endif
endmodule

// File: doc/l2_responder.md
L2_RESPONDER -- requirements
Module: l2_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, word-address width of the backing store (1024 words).
REQ-002 SHALL have parameter XLEN, default 32, data word width.
REQ-003 SHALL have parameter LATENCY, default 4, wait cycles per word access; legal range 1..15.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port l2_req_valid  input  1  request present from the dcache side, held high for the whole burst.
REQ-007 SHALL have port l2_req_type  input  memory_operation_e  LOAD or STORE; any other value is ignored.
REQ-008 SHALL have port l2_req_address  input  ADDR_WIDTH  word address of the current beat.
REQ-009 SHALL have port l2_req_store_word  input  XLEN  write data for a STORE beat.
REQ-010 SHALL have port l2_req_fulfilled  output  1  one-cycle pulse: the current beat is complete.
REQ-011 SHALL have port l2_req_loaded_word  output  XLEN  read data for a LOAD beat, valid in the fulfilled cycle.

Function
REQ-012 SHALL implement FSM states ST_IDLE, ST_BUSY, ST_RESPOND and ST_GAP.
REQ-013 In ST_IDLE with l2_req_valid=1 and type LOAD/STORE, SHALL latch address, type and store word, load wait_cnt=LATENCY-1, and go to ST_BUSY.
REQ-014 In ST_IDLE with valid=0 or an illegal type, SHALL remain in ST_IDLE with no side effects.
REQ-015 In ST_BUSY, SHALL go to ST_RESPOND when wait_cnt==0, else decrement wait_cnt.
REQ-016 SHALL launch the array read in the final ST_BUSY cycle so that read data is present in ST_RESPOND.
REQ-017 In ST_RESPOND, SHALL assert l2_req_fulfilled for exactly one cycle, then go to ST_GAP.
REQ-018 For STORE, SHALL write the latched word to the latched address in the ST_RESPOND cycle.
REQ-019 In ST_GAP, SHALL ignore l2_req_valid for exactly one cycle, then go to ST_IDLE; this absorbs the initiator's stale valid/address cycle after its counter update.
REQ-020 Latency: valid sampled in ST_IDLE at cycle t SHALL produce fulfilled at t+LATENCY+1, and the next beat SHALL be sampled no earlier than t+LATENCY+3.
REQ-021 Once latched, a request SHALL complete even if l2_req_valid falls mid-access.
REQ-022 l2_req_loaded_word SHALL be registered, SHALL update only on LOAD responses, and SHALL hold its value otherwise.
REQ-023 A LOAD following a STORE to the same address SHALL return the stored data.
REQ-024 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH; no out-of-range handling is required.

Reset
REQ-025 While reset_n=0, SHALL force state to ST_IDLE, wait_cnt to 0, l2_req_fulfilled to 0 and l2_req_loaded_word to 0.
REQ-026 Reset asserted mid-operation SHALL abort the pending beat with no array write and no fulfilled pulse; array contents SHALL be preserved.

Configuration
REQ-027 Macro XENTRY_L2_STATS_EN, when defined, SHALL add outputs load_count and store_count, each 32 bits; each SHALL increment by 1 per fulfilled LOAD or STORE beat respectively, SHALL reset to 0, and SHALL saturate at all-ones.
REQ-028 When XENTRY_L2_STATS_EN is undefined, these ports and counters SHALL be absent and behaviour SHALL otherwise be identical.

Structure
REQ-029 memory_operation_e (LOAD, STORE, MO_UNKNOWN) SHALL come from xentry_pkg; an l2_responder_state_e enum SHALL also live there.
REQ-030 The storage SHALL be a sub-module l2_memory_array: single-port, synchronous read and write, parameterised by ADDR_WIDTH and XLEN.

Verification
REQ-031 Reset then LOAD of address 0x005 with LATENCY=4 -> fulfilled exactly 5 cycles after sampling, loaded_word=0x00000000 for an uninitialised (zero-preloaded) array.
REQ-032 STORE 0xDEADBEEF to 0x010, then LOAD 0x010 -> loaded_word=0xDEADBEEF in the fulfilled cycle.
REQ-033 Four-beat STORE burst to 0x020..0x023 with valid held high throughout -> exactly 4 fulfilled pulses, each beat followed by one ST_GAP cycle, and no fifth spurious access.
REQ-034 LATENCY=1 LOAD -> fulfilled 2 cycles after sampling.
REQ-035 reset_n=0 during ST_BUSY of a STORE 0x12345678 to 0x030 -> no fulfilled pulse; a following LOAD of 0x030 returns the prior contents.
REQ-036 With XENTRY_L2_STATS_EN, 3 LOAD beats and 2 STORE beats -> load_count=3, store_count=2; both read 0 after reset.
